// File: rtl/rc_ladder_sim_pkg.sv
// rc_sim_pkg: shared types and constants for the RC-ladder node simulator.
// Optional build macro NODE_SAT_EN (used in rc_node_update) selects saturation
// instead of two's-complement wrap on the narrowed node result.
package rc_sim_pkg;

  // Step sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CALC   = 2'd2,
    ST_COMMIT = 2'd3
  } rc_state_e;

  // Default Q(INT.FRAC) format and derived widths
  localparam int INT_W_DEF  = 16;
  localparam int FRAC_W_DEF = 16;
  localparam int W_DEF      = INT_W_DEF + FRAC_W_DEF;
  localparam int DW_DEF     = W_DEF + 1;   // difference width
  localparam int GAIN_W     = 8;           // unsigned gain fits in 8 bits

  // Signed W-bit limits for the default format
  localparam logic [W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic [W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(W_DEF-1){1'b0}}};

  // Q-format helpers: 1.0 and 0.5 in the default format
  localparam logic [W_DEF-1:0] Q_ONE_DEF  = W_DEF'(1) << FRAC_W_DEF;
  localparam logic [W_DEF-1:0] Q_HALF_DEF = W_DEF'(1) << (FRAC_W_DEF - 1);

  // Channel index width; a single-node ladder still needs one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rc_ladder_sim_if.sv
// rc_ladder_sim_if: step request / node readout bundle for rc_ladder_sim.
// master = board-level controller, slave = simulator core.
interface rc_ladder_sim_if
  import rc_sim_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
);
  localparam int W = INT_W + FRAC_W;

  logic                    step_start;
  logic                    clear;
  logic [W-1:0]            vin;
  logic                    busy;
  logic                    done;
  logic                    step_clk;
  logic [31:0]             step_cnt;
  logic [NCH*INT_W-1:0]    v_int_o;
  logic [NCH*FRAC_W-1:0]   v_frac_o;

  modport master (
    output step_start, clear, vin,
    input  busy, done, step_clk, step_cnt, v_int_o, v_frac_o
  );

  modport slave (
    input  step_start, clear, vin,
    output busy, done, step_clk, step_cnt, v_int_o, v_frac_o
  );

endinterface

// File: rtl/rc_ladder_sim_node_update.sv
// rc_node_update: one forward-Euler step for a single node,
//   next = node + ((src - node) * GAIN) >>> SHIFT
// The sum is formed at full width before narrowing to W bits.
// NODE_SAT_EN defined: clamp to signed W-bit limits; otherwise wrap.
module rc_node_update
  import rc_sim_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int GAIN  = 1,
  parameter int SHIFT = 1
) (
  input  logic [W-1:0] src,
  input  logic [W-1:0] node,
  output logic [W-1:0] nxt
);
  localparam int DW = W + 1;
  localparam int PW = DW + GAIN_W;
  localparam logic signed [PW-1:0] GAIN_X = PW'(GAIN);

  logic signed [DW-1:0] diff;
  logic signed [PW-1:0] prod;

  // Difference and product never overflow their widths (|diff| <= 2^W, GAIN < 2^8)
  assign diff = $signed({src[W-1], src}) - $signed({node[W-1], node});
  assign prod = $signed({{GAIN_W{diff[DW-1]}}, diff}) * GAIN_X;

`ifdef NODE_SAT_EN
  localparam int SW = PW + 1;
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [PW-1:0] shd;
  logic signed [SW-1:0] sum;

  assign shd = prod >>> SHIFT;
  assign sum = $signed({{(SW-W){node[W-1]}}, node}) + $signed({shd[PW-1], shd});

  // Clamp when the bits above the W-bit sign position disagree
  always_comb begin
    nxt = sum[W-1:0];
    if (!((sum[SW-1:W-1] == '0) || (sum[SW-1:W-1] == '1)))
      nxt = sum[SW-1] ? SAT_MIN : SAT_MAX;
  end
`else
  // Keep only the low W bits of the full-width sum
  assign nxt = node + W'(prod >>> SHIFT);
`endif

endmodule

// File: rtl/rc_ladder_sim.sv
// rc_ladder_sim: NCH-node RC-ladder simulator in signed Q(INT_W.FRAC_W).
// Each requested step snapshots vin and all nodes, then evaluates one channel
// per cycle through a shared rc_node_update and commits all nodes together
// (Jacobi update). Build macro NODE_SAT_EN enables result saturation.
module rc_ladder_sim
  import rc_sim_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int GAIN   = 1,
  parameter int SHIFT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  rc_ladder_sim_if.slave   bus
);
  localparam int W  = INT_W + FRAC_W;
  localparam int IW = idx_w(NCH);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  rc_state_e state, state_nxt;
  logic load_en, calc_en, commit_en, clear_en, busy;

  logic [IW-1:0]          idx;
  logic [W-1:0]           vin_s, src, nxt;
  logic [NCH-1:0][W-1:0]  node_q, node_s, pend;
  logic [31:0]            step_cnt_q;
  logic                   step_clk_q, done_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: clear in IDLE wins over step_start; requests while busy are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.step_start && !bus.clear) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_CALC;
      ST_CALC:   if (idx == LAST) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-state datapath enables
  always_comb begin
    load_en   = (state == ST_LOAD);
    calc_en   = (state == ST_CALC);
    commit_en = (state == ST_COMMIT);
    clear_en  = (state == ST_IDLE) && bus.clear;
    busy      = (state != ST_IDLE);
  end

  // Source for the channel under evaluation: vin for node 0, else the previous node
  always_comb begin
    src = vin_s;
    if (idx != '0) src = node_s[idx - IW'(1)];
  end

  rc_node_update #(.W(W), .GAIN(GAIN), .SHIFT(SHIFT)) u_upd (
    .src  (src),
    .node (node_s[idx]),
    .nxt  (nxt)
  );

  // Snapshot at LOAD, then walk the channels collecting pending results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin_s  <= '0;
      node_s <= '0;
      pend   <= '0;
      idx    <= '0;
    end else if (load_en) begin
      vin_s  <= bus.vin;
      node_s <= node_q;
      idx    <= '0;
    end else if (calc_en) begin
      pend[idx] <= nxt;
      idx       <= idx + IW'(1);
    end
  end

  // Node registers change only on an idle clear or at COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         node_q <= '0;
    else if (clear_en)  node_q <= '0;
    else if (commit_en) node_q <= pend;
  end

  // Step bookkeeping: counter wraps naturally, step clock toggles, done follows COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      step_clk_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= commit_en;
      if (commit_en) begin
        step_cnt_q <= step_cnt_q + 32'd1;
        step_clk_q <= ~step_clk_q;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.step_clk = step_clk_q;
  assign bus.step_cnt = step_cnt_q;

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign bus.v_int_o[k*INT_W +: INT_W]    = node_q[k][W-1 -: INT_W];
    assign bus.v_frac_o[k*FRAC_W +: FRAC_W] = node_q[k][FRAC_W-1:0];
  end

endmodule

// File: tb/tb_rc_ladder_sim.sv
// tb_rc_ladder_sim: two simulator instances (GAIN=1/SHIFT=1 and GAIN=4/SHIFT=0)
// share one stimulus stream and are compared against an arithmetic model of
// the ladder. NODE_SAT_EN selects the expected overflow behaviour.
module tb_rc_ladder_sim;
  import rc_sim_pkg::*;

  localparam int NCH = 2;
  localparam int IW  = 16;
  localparam int FW  = 16;
  localparam int W   = IW + FW;
  localparam int GA  = 1, SA = 1;
  localparam int GB  = 4, SB = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc_ladder_sim_if #(.NCH(NCH), .INT_W(IW), .FRAC_W(FW)) ifa ();
  rc_ladder_sim_if #(.NCH(NCH), .INT_W(IW), .FRAC_W(FW)) ifb ();

  rc_ladder_sim #(.NCH(NCH), .INT_W(IW), .FRAC_W(FW), .GAIN(GA), .SHIFT(SA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  rc_ladder_sim #(.NCH(NCH), .INT_W(IW), .FRAC_W(FW), .GAIN(GB), .SHIFT(SB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] ma [NCH];
  logic [W-1:0] mb [NCH];
  logic [31:0]  cnt_a, cnt_b;
  logic         sclk_a, sclk_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: one Euler step in 64-bit integer arithmetic, then narrow
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] src, input logic [W-1:0] node,
                                            input int gain, input int shift);
    longint d, p, s;
    d = longint'($signed(src)) - longint'($signed(node));
    p = d * longint'(gain);
    s = longint'($signed(node)) + (p >>> shift);
`ifdef NODE_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] node_a(input int k);
    return {ifa.v_int_o[k*IW +: IW], ifa.v_frac_o[k*FW +: FW]};
  endfunction

  function automatic logic [W-1:0] node_b(input int k);
    return {ifb.v_int_o[k*IW +: IW], ifb.v_frac_o[k*FW +: FW]};
  endfunction

  task automatic set_in(input logic s, input logic c, input logic [W-1:0] v);
    ifa.step_start = s; ifb.step_start = s;
    ifa.clear = c;      ifb.clear = c;
    ifa.vin = v;        ifb.vin = v;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin ma[k] = '0; mb[k] = '0; end
    cnt_a = '0; cnt_b = '0; sclk_a = 1'b0; sclk_b = 1'b0;
  endtask

  // Every node reads the previous step's values (old copies), i.e. Jacobi
  task automatic model_step(input logic [W-1:0] v);
    logic [W-1:0] oa [NCH];
    logic [W-1:0] ob [NCH];
    oa = ma; ob = mb;
    for (int k = 0; k < NCH; k++) begin
      if (k == 0) begin
        ma[k] = ref_next(v, oa[k], GA, SA);
        mb[k] = ref_next(v, ob[k], GB, SB);
      end else begin
        ma[k] = ref_next(oa[k-1], oa[k], GA, SA);
        mb[k] = ref_next(ob[k-1], ob[k], GB, SB);
      end
    end
    cnt_a++; cnt_b++; sclk_a = ~sclk_a; sclk_b = ~sclk_b;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("%s a.node%0d", tag, k), node_a(k), ma[k]);
      check($sformatf("%s b.node%0d", tag, k), node_b(k), mb[k]);
    end
    check({tag, " a.step_cnt"}, ifa.step_cnt, cnt_a);
    check({tag, " b.step_cnt"}, ifb.step_cnt, cnt_b);
    check({tag, " a.step_clk"}, ifa.step_clk, sclk_a);
    check({tag, " b.step_clk"}, ifb.step_clk, sclk_b);
  endtask

  // One step; optionally re-pulse step_start or clear while the step is in CALC
  task automatic run_step(input logic [W-1:0] v, input bit poke_start, input bit poke_clear);
    int lat;
    bit seen;
    @(negedge clk); set_in(1'b1, 1'b0, v);
    @(negedge clk); set_in(1'b0, 1'b0, v);
    check("busy_a", ifa.busy, 1);
    check("busy_b", ifb.busy, 1);
    seen = 1'b0; lat = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        set_in(poke_start, poke_clear, ~v);
        check("hold a.node0", node_a(0), ma[0]);
      end
      if (k == 2) set_in(1'b0, 1'b0, v);
      if (ifa.done) begin seen = 1'b1; lat = k; end
    end
    check("done_latency", lat, NCH + 2);
    check("done_b", ifb.done, 1);
    model_step(v);
    check_all("step");
    @(negedge clk);
    check("done_pulse", ifa.done, 0);
    check("idle_busy", ifa.busy, 0);
  endtask

  task automatic do_clear(input bit with_start);
    @(negedge clk); set_in(with_start, 1'b1, 32'h1234_5678);
    @(negedge clk); set_in(1'b0, 1'b0, '0);
    check("clear busy_a", ifa.busy, 0);
    for (int k = 0; k < NCH; k++) begin ma[k] = '0; mb[k] = '0; end
    check_all("clear");
    @(negedge clk);
    check("clear busy_a2", ifa.busy, 0);
    check("clear busy_b2", ifb.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rv;
    int r;
    set_in(1'b0, 1'b0, '0);
    model_reset();
    #32;
    check_all("reset");
    check("reset busy_a", ifa.busy, 0);
    check("reset done_a", ifa.done, 0);
    @(negedge clk); rst_n = 1'b1;

    // Step response from rest with vin = 1.0
    run_step(32'h0001_0000, 1'b0, 1'b0);
    check("sr1 node0", node_a(0), 32'h0000_8000);
    check("sr1 node1", node_a(1), 32'h0000_0000);
    run_step(32'h0001_0000, 1'b0, 1'b0);
    check("sr2 node0", node_a(0), 32'h0000_C000);
    check("sr2 node1", node_a(1), 32'h0000_4000);
    check("sr2 step_cnt", ifa.step_cnt, 2);
    check("sr2 step_clk", ifa.step_clk, 0);

    // step_start re-pulsed mid-step counts once
    run_step(32'h0002_0000, 1'b1, 1'b0);
    check("collide step_cnt", ifa.step_cnt, 3);

    // clear and step_start together in IDLE: clear only
    do_clear(1'b1);

    // Overshoot: GAIN=4, SHIFT=0, vin = 0x4000_0000 from zero
    run_step(32'h4000_0000, 1'b0, 1'b0);
`ifdef NODE_SAT_EN
    check("overshoot node0", node_b(0), 32'h7FFF_FFFF);
`else
    check("overshoot node0", node_b(0), 32'h0000_0000);
`endif
    check("overshoot a.node0", node_a(0), 32'h2000_0000);

    // clear while busy is ignored
    run_step(32'hFFF0_0000, 1'b0, 1'b1);

    // Randomised mix of steps, idle clears and mid-step pokes
    for (int i = 0; i < 20; i++) begin
      r  = $urandom_range(0, 7);
      rv = $urandom;
      if (r == 0) do_clear(1'b0);
      else        run_step(rv, r == 1, r == 2);
    end

    // Reset in the middle of CALC abandons the step
    @(negedge clk); set_in(1'b1, 1'b0, 32'h0003_0000);
    @(negedge clk); set_in(1'b0, 1'b0, 32'h0003_0000);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    check("midrst busy_a", ifa.busy, 0);
    check("midrst done_a", ifa.done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check_all("postrst");
    check("postrst busy_a", ifa.busy, 0);

    // Counter wrap from 0xFFFF_FFFF
    @(negedge clk);
    force dut_a.step_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_a.step_cnt_q;
    @(negedge clk);
    check("preload step_cnt", ifa.step_cnt, 32'hFFFF_FFFF);
    cnt_a = 32'hFFFF_FFFF;
    run_step(32'h0000_8000, 1'b0, 1'b0);
    check("wrap step_cnt", ifa.step_cnt, 0);
    check("wrap step_clk", ifa.step_clk, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
